// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and address map for the APB requester.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int          NUM_SLAVES = 4;
  localparam logic [31:0] SLV0_BASE  = 32'h1000_0000;
  localparam logic [31:0] SLV1_BASE  = 32'h1000_1000;
  localparam logic [31:0] SLV2_BASE  = 32'h1000_2000;
  localparam logic [31:0] SLV3_BASE  = 32'h1000_3000;
  localparam logic [31:0] DEC_MASK   = 32'hFFFF_F000;

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - CPU request side plus APB bus signals of the requester.
interface apb_master_if;
  import apb_pkg::*;

  logic                  transfer;
  logic                  write;
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  error;

  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic                  PENABLE;
  logic [NUM_SLAVES-1:0] PSEL;
  logic [31:0]           PRDATA0;
  logic [31:0]           PRDATA1;
  logic [31:0]           PRDATA2;
  logic [31:0]           PRDATA3;
  logic [NUM_SLAVES-1:0] PREADY;

  modport master (
    input  transfer, write, addr, wdata,
    output rdata, ready, error,
    output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

  modport slave (
    output transfer, write, addr, wdata,
    input  rdata, ready, error,
    input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PREADY
  );

endinterface

// File: rtl/apb_master_addr_decoder.sv
// rtl/apb_master_addr_decoder.sv - maps a CPU byte address onto a one-hot slave select.
module apb_addr_decoder
  import apb_pkg::*;
(
  input  logic [31:0]           i_addr,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_hit
);

  logic [31:0] w_page;

  assign w_page   = i_addr & DEC_MASK;
  assign o_sel[0] = (w_page == SLV0_BASE);
  assign o_sel[1] = (w_page == SLV1_BASE);
  assign o_sel[2] = (w_page == SLV2_BASE);
  assign o_sel[3] = (w_page == SLV3_BASE);
  assign o_hit    = |o_sel;

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-request APB requester with address decode and ACCESS timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  apb_state_e            r_state;
  logic [CW-1:0]         r_cnt;
  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_penable;
  logic [31:0]           r_paddr;
  logic                  r_pwrite;
  logic [31:0]           r_pwdata;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_error;

  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_hit;
  logic                  w_pready;
  logic [31:0]           w_prdata;

  apb_addr_decoder u_dec (
    .i_addr (bus.addr),
    .o_sel  (w_sel),
    .o_hit  (w_hit)
  );

  // PSEL stays one-hot through SETUP/ACCESS, so it doubles as the return-path select.
  assign w_pready = |(bus.PREADY & r_psel);
  assign w_prdata = ({32{r_psel[0]}} & bus.PRDATA0) |
                    ({32{r_psel[1]}} & bus.PRDATA1) |
                    ({32{r_psel[2]}} & bus.PRDATA2) |
                    ({32{r_psel[3]}} & bus.PRDATA3);

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.transfer) begin
            if (w_hit) begin
              r_paddr  <= bus.addr;
              r_pwrite <= bus.write;
              r_pwdata <= bus.wdata;
              r_psel   <= w_sel;
              r_cnt    <= '0;
              r_state  <= SETUP;
            end else begin
              r_ready <= 1'b1;
              r_error <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_pready) begin
            if (!r_pwrite) begin
              r_rdata <= w_prdata;
            end
            r_ready   <= 1'b1;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= IDLE;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_ready   <= 1'b1;
            r_error   <= 1'b1;
            r_rdata   <= '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.PSEL    = r_psel;
  assign bus.PENABLE = r_penable;
  assign bus.PADDR   = r_paddr;
  assign bus.PWRITE  = r_pwrite;
  assign bus.PWDATA  = r_pwdata;
  assign bus.rdata   = r_rdata;
  assign bus.ready   = r_ready;
  assign bus.error   = r_error;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master with RAM, zero-wait and hung slave models.
module tb_apb_master;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_cyc;

  always #5 PCLK = ~PCLK;

  apb_master_if bus_if ();

  apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus_if)
  );

  // RAM slave: PREADY registered one cycle after PSEL&PENABLE, stale for one cycle after.
  logic [31:0] ram [16];
  logic        ram_rdy;

  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ram_rdy <= 1'b0;
      for (int i = 0; i < 16; i++) ram[i] <= 32'hA5A5_0000 + 32'(i);
    end else begin
      ram_rdy <= bus_if.PSEL[0] & bus_if.PENABLE;
      if (bus_if.PSEL[0] && bus_if.PENABLE && bus_if.PWRITE && ram_rdy)
        ram[bus_if.PADDR[5:2]] <= bus_if.PWDATA;
    end
  end

  assign bus_if.PRDATA0 = ram[bus_if.PADDR[5:2]];
  assign bus_if.PRDATA1 = {20'h11111, bus_if.PADDR[11:0]};
  assign bus_if.PRDATA2 = 32'h2222_2222;
  assign bus_if.PRDATA3 = 32'h3333_3333;
  assign bus_if.PREADY  = {1'b1, 1'b0, 1'b1, ram_rdy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Issue one request; n returns the cycle (T0 = accept) in which ready is seen.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output int n);
    bus_if.transfer = 1'b1;
    bus_if.write    = w;
    bus_if.addr     = a;
    bus_if.wdata    = d;
    tick();
    bus_if.transfer = 1'b0;
    n = 1;
    while (!bus_if.ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.transfer = 1'b0;
    bus_if.write    = 1'b0;
    bus_if.addr     = '0;
    bus_if.wdata    = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_psel",    32'(bus_if.PSEL),    32'h0);
    check("rst_penable", 32'(bus_if.PENABLE), 32'h0);
    check("rst_ready",   32'(bus_if.ready),   32'h0);
    check("rst_error",   32'(bus_if.error),   32'h0);
    check("rst_rdata",   bus_if.rdata,        32'h0);
    check("rst_paddr",   bus_if.PADDR,        32'h0);
    PRESET = 1'b1;
    tick();

    // Write to RAM, phase by phase.
    bus_if.transfer = 1'b1;
    bus_if.write    = 1'b1;
    bus_if.addr     = 32'h1000_0008;
    bus_if.wdata    = 32'hDEAD_BEEF;
    tick();
    bus_if.transfer = 1'b0;
    check("wr_t1_psel",    32'(bus_if.PSEL),    32'h1);
    check("wr_t1_penable", 32'(bus_if.PENABLE), 32'h0);
    check("wr_t1_paddr",   bus_if.PADDR,        32'h1000_0008);
    check("wr_t1_pwrite",  32'(bus_if.PWRITE),  32'h1);
    check("wr_t1_pwdata",  bus_if.PWDATA,       32'hDEAD_BEEF);
    tick();
    check("wr_t2_penable", 32'(bus_if.PENABLE), 32'h1);
    tick();
    check("wr_t3_ready",   32'(bus_if.ready),   32'h0);
    tick();
    check("wr_t4_ready",   32'(bus_if.ready),   32'h1);
    check("wr_t4_error",   32'(bus_if.error),   32'h0);
    check("wr_t4_psel",    32'(bus_if.PSEL),    32'h0);
    check("wr_ram2",       ram[2],              32'hDEAD_BEEF);
    tick();
    check("wr_t5_ready",   32'(bus_if.ready),   32'h0);

    // Read back; address and direction stable T1..T3.
    bus_if.transfer = 1'b1;
    bus_if.write    = 1'b0;
    bus_if.addr     = 32'h1000_0008;
    tick();
    bus_if.transfer = 1'b0;
    bus_if.addr     = 32'h0;
    for (int t = 1; t <= 3; t++) begin
      check($sformatf("rd_t%0d_paddr", t),  bus_if.PADDR,       32'h1000_0008);
      check($sformatf("rd_t%0d_pwrite", t), 32'(bus_if.PWRITE), 32'h0);
      tick();
    end
    check("rd_t4_ready", 32'(bus_if.ready), 32'h1);
    check("rd_t4_error", 32'(bus_if.error), 32'h0);
    check("rd_t4_rdata", bus_if.rdata,      32'hDEAD_BEEF);
    tick();

    // Unmapped read.
    bus_if.transfer = 1'b1;
    bus_if.addr     = 32'h2000_0000;
    tick();
    bus_if.transfer = 1'b0;
    check("um_psel",  32'(bus_if.PSEL),  32'h0);
    check("um_ready", 32'(bus_if.ready), 32'h1);
    check("um_error", 32'(bus_if.error), 32'h1);
    check("um_rdata", bus_if.rdata,      32'h0);
    tick();
    check("um_ready_drop", 32'(bus_if.ready), 32'h0);
    check("um_psel_t2",    32'(bus_if.PSEL),  32'h0);

    // Hung slave2: 16 ACCESS cycles (T2..T17) then error at T18.
    xfer(1'b0, 32'h1000_2000, 32'h0, n_cyc);
    check("to_latency", 32'(n_cyc),          32'd18);
    check("to_error",   32'(bus_if.error),   32'h1);
    check("to_psel",    32'(bus_if.PSEL),    32'h0);
    check("to_penable", 32'(bus_if.PENABLE), 32'h0);
    check("to_rdata",   bus_if.rdata,        32'h0);
    tick();
    xfer(1'b0, 32'h1000_0008, 32'h0, n_cyc);
    check("after_to_latency", 32'(n_cyc),        32'd4);
    check("after_to_error",   32'(bus_if.error), 32'h0);
    check("after_to_rdata",   bus_if.rdata,      32'hDEAD_BEEF);
    tick();

    // Zero-wait slave1: ready at T3.
    xfer(1'b0, 32'h1000_1004, 32'h0, n_cyc);
    check("zw_latency", 32'(n_cyc),        32'd3);
    check("zw_error",   32'(bus_if.error), 32'h0);
    check("zw_rdata",   bus_if.rdata,      32'h1111_1004);
    tick();

    // Back-to-back with transfer held high.
    bus_if.transfer = 1'b1;
    bus_if.write    = 1'b1;
    bus_if.addr     = 32'h1000_0004;
    bus_if.wdata    = 32'hCAFE_F00D;
    tick();
    bus_if.write    = 1'b0;
    bus_if.wdata    = 32'h0;
    check("b2b_t1_pwrite", 32'(bus_if.PWRITE), 32'h1);
    tick();
    tick();
    tick();
    check("b2b_t4_ready", 32'(bus_if.ready), 32'h1);
    check("b2b_t4_error", 32'(bus_if.error), 32'h0);
    tick();
    bus_if.transfer = 1'b0;
    check("b2b_t5_psel",   32'(bus_if.PSEL),   32'h1);
    check("b2b_t5_pwrite", 32'(bus_if.PWRITE), 32'h0);
    check("b2b_t5_ready",  32'(bus_if.ready),  32'h0);
    n_cyc = 1;
    while (!bus_if.ready && n_cyc < 40) begin
      tick();
      n_cyc++;
    end
    check("b2b_rd_latency", 32'(n_cyc),   32'd4);
    check("b2b_rd_rdata",   bus_if.rdata, 32'hCAFE_F00D);
    check("b2b_ram1",       ram[1],       32'hCAFE_F00D);
    tick();

    // Transfer pulse during ACCESS must be ignored.
    bus_if.transfer = 1'b1;
    bus_if.addr     = 32'h1000_0004;
    tick();
    bus_if.transfer = 1'b0;
    tick();
    bus_if.transfer = 1'b1;
    bus_if.addr     = 32'h2000_0000;
    tick();
    bus_if.transfer = 1'b0;
    bus_if.addr     = 32'h0;
    check("ign_t3_paddr", bus_if.PADDR, 32'h1000_0004);
    tick();
    check("ign_t4_ready", 32'(bus_if.ready), 32'h1);
    check("ign_t4_error", 32'(bus_if.error), 32'h0);
    check("ign_t4_rdata", bus_if.rdata,      32'hCAFE_F00D);
    tick();
    check("ign_t5_ready", 32'(bus_if.ready), 32'h0);
    check("ign_t5_psel",  32'(bus_if.PSEL),  32'h0);

    // Reset asserted mid-ACCESS.
    bus_if.transfer = 1'b1;
    bus_if.addr     = 32'h1000_0000;
    tick();
    bus_if.transfer = 1'b0;
    tick();
    check("mr_in_access", 32'(bus_if.PENABLE), 32'h1);
    PRESET = 1'b0;
    #1;
    check("mr_psel",    32'(bus_if.PSEL),    32'h0);
    check("mr_penable", 32'(bus_if.PENABLE), 32'h0);
    check("mr_paddr",   bus_if.PADDR,        32'h0);
    check("mr_pwrite",  32'(bus_if.PWRITE),  32'h0);
    check("mr_pwdata",  bus_if.PWDATA,       32'h0);
    check("mr_rdata",   bus_if.rdata,        32'h0);
    check("mr_ready",   32'(bus_if.ready),   32'h0);
    check("mr_error",   32'(bus_if.error),   32'h0);
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    xfer(1'b0, 32'h1000_0000, 32'h0, n_cyc);
    check("mr_rd_latency", 32'(n_cyc),        32'd4);
    check("mr_rd_error",   32'(bus_if.error), 32'h0);
    check("mr_rd_rdata",   bus_if.rdata,      32'hA5A5_0000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
